// File: rtl/ascii_disp_pkg.sv
// ascii_disp_pkg
// Shared types and constants for the seven-segment message scroller.
//   state_t     : scroll sequencer states (IDLE / SCROLL / DONE)
//   ASCII_SPACE : code driven on a blanked digit
//   BLANK_SEGS  : segment pattern (active-low, all off) used by the decoders
package ascii_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [6:0] BLANK_SEGS  = 7'h7F;

endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen
// Free-running divider producing one scroll step every TICK_DIV cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   clr   : holds the divider at zero; the first tick after clr drops
//           arrives TICK_DIV cycles after the clearing edge
//   tick  : one-cycle pulse
module scroll_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/ascii_scroll_ctrl.sv
// ascii_scroll_ctrl
// Message buffer and leftward scroll sequencer for a bank of ASCII
// seven-segment digits.
// Build option: SCROLL_LOOP_EN -- when defined the message wraps around
// forever and DONE is never entered; otherwise one pass then DONE.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   wr_valid/wr_char     : character write offer (accepted when wr_ready)
//   wr_ready             : IDLE and buffer not full
//   start/stop/clear     : one-cycle command pulses
//   busy, done           : state != IDLE, one-cycle end-of-pass pulse
//   msg_len              : stored character count
//   digit_code           : ASCII per digit, top byte = leftmost digit
//   digit_blank          : 1 = digit forced off
//   dbg_state            : current sequencer state
// Handshake: a character transfers on a rising edge where wr_valid and
// wr_ready are both high; wr_ready does not depend on wr_valid.
module ascii_scroll_ctrl
  import ascii_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_DEPTH  = 32,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_char,
  output logic                          wr_ready,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MSG_DEPTH):0]    msg_len,
  output logic [8*NUM_DIGITS-1:0]       digit_code,
  output logic [NUM_DIGITS-1:0]         digit_blank,
  output state_t                        dbg_state
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  // pos + k can reach about 2*(MSG_DEPTH+NUM_DIGITS); one spare bit covers it
  localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;

  logic [7:0]    r_buf [MSG_DEPTH];
  state_t        r_state;
  logic [LW-1:0] r_msg_len;
  logic [PW-1:0] r_pos;
  logic          r_busy;
  logic          r_done;

  logic          w_tick;
  logic          w_tick_clr;
  logic          w_wr_fire;
  logic [LW-1:0] w_len_base;
  logic [AW-1:0] w_wr_idx;
  logic [LW-1:0] w_len_nxt;
  logic [PW-1:0] w_len_ext;
  logic [PW-1:0] w_pos_inc;
  logic [PW-1:0] w_idx;
`ifdef SCROLL_LOOP_EN
  logic [PW-1:0] w_period;
  assign w_period = w_len_ext + PW'(NUM_DIGITS);
`endif

  assign wr_ready  = (r_state == ST_IDLE) && (r_msg_len < LW'(MSG_DEPTH));
  assign w_wr_fire = wr_valid && wr_ready;
  // A write in the same cycle as clear lands at index 0 of the new message.
  assign w_len_base = clear ? '0 : r_msg_len;
  assign w_wr_idx   = w_len_base[AW-1:0];
  assign w_len_nxt  = w_len_base + LW'(w_wr_fire);
  assign w_len_ext  = PW'(r_msg_len);
  assign w_pos_inc  = r_pos + PW'(1);
  assign w_tick_clr = (r_state != ST_SCROLL);

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  // Buffer contents need no reset: only indices below msg_len are read.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_fire) begin
      r_buf[w_wr_idx] <= wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_msg_len <= '0;
      r_pos     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_msg_len <= w_len_nxt;
          // A character accepted alongside start belongs to the message.
          if (start && (w_len_nxt != '0)) begin
            r_state <= ST_SCROLL;
            r_pos   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCROLL: begin
          // stop outranks a tick landing in the same cycle
          if (stop) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
`ifdef SCROLL_LOOP_EN
            r_pos <= (w_pos_inc == w_period) ? '0 : w_pos_inc;
`else
            // Window would be all blank: the pass is over.
            if (w_pos_inc == w_len_ext) begin
              r_state <= ST_DONE;
              r_pos   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_pos <= w_pos_inc;
            end
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Window: digit k from the left shows stream index pos+k; indices past the
  // message (the trailing NUM_DIGITS positions) are blank.
  always_comb begin
    digit_code  = {NUM_DIGITS{ASCII_SPACE}};
    digit_blank = '1;
    w_idx       = '0;
    if (r_state == ST_SCROLL) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        w_idx = r_pos + PW'(k);
`ifdef SCROLL_LOOP_EN
        if (w_idx >= w_period) begin
          w_idx = w_idx - w_period;
        end
`endif
        if (w_idx < w_len_ext) begin
          digit_code[8*(NUM_DIGITS-1-k) +: 8] = r_buf[w_idx[AW-1:0]];
          digit_blank[NUM_DIGITS-1-k]         = 1'b0;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign msg_len   = r_msg_len;
  assign dbg_state = r_state;

endmodule

// File: doc/ascii_scroll_ctrl.md
# ascii_scroll_ctrl

Message buffer and scroll sequencer for the board's bank of seven-segment digits. It accepts ASCII characters over a valid/ready write port and stores up to MSG_DEPTH of them. On command it scrolls the message leftward across NUM_DIGITS positions at a fixed tick rate. Per-digit ASCII codes and blank flags go to the existing ASCII-to-segment decoders in the display top level.

## Interface
- NUM_DIGITS, 6, number of display digits driven
- MSG_DEPTH, 32, message buffer capacity in characters (power of two)
- TICK_DIV, 25_000_000, clock cycles per scroll step
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  character offered
- wr_char  in  8  ASCII character
- wr_ready  out  1  buffer accepts write this cycle
- start  in  1  one-cycle pulse, begin scrolling
- stop  in  1  one-cycle pulse, abort scrolling
- clear  in  1  one-cycle pulse, empty buffer (IDLE only)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, single pass finished
- msg_len  out  $clog2(MSG_DEPTH)+1  stored character count
- digit_code  out  8*NUM_DIGITS  ASCII per digit, digit NUM_DIGITS-1 = leftmost
- digit_blank  out  NUM_DIGITS  1 = top level forces that digit's segments off

## Operation
- States: IDLE, SCROLL, DONE.
- IDLE: write accepted when wr_valid && wr_ready. Char stored at index msg_len, msg_len++. wr_ready = (state==IDLE) && (msg_len<MSG_DEPTH). clear sets msg_len=0. Display fully blank.
- IDLE + start + msg_len>0 -> SCROLL, pos=0, tick counter=0. start with msg_len==0 ignored.
- A write accepted in the start cycle is part of the message.
- Stream S = message followed by NUM_DIGITS blanks, period P = msg_len+NUM_DIGITS.
- Digit k from left (k=0..NUM_DIGITS-1) shows S[pos+k]. Blank positions drive code 8'h20 with blank=1.
- Each tick: pos++.
- SCROLL + stop -> IDLE. Message retained; next start restarts at pos 0. stop beats a simultaneous tick.
- start, clear and writes are ignored outside IDLE.
- DONE: done=1 for one cycle, display blank, then IDLE.

## Timing
- Reset values: state IDLE, msg_len 0, pos 0, busy 0, done 0, wr_ready 1, digit_code all 8'h20, digit_blank all 1.
- Digit outputs are combinational from registered state/pos/buffer. The new window is visible the cycle after the start or tick edge.
- First step occurs TICK_DIV cycles after entering SCROLL. Subsequent steps occur every TICK_DIV cycles.
- Reset mid-scroll: IDLE and buffer empty on the next edge.

## Configuration
- SCROLL_LOOP_EN defined: index is (pos+k) mod P, and pos wraps from P-1 to 0. The message re-enters from the right indefinitely. DONE is never entered and done is never pulsed.
- SCROLL_LOOP_EN undefined: the tick that would set pos=msg_len (window all blank) instead moves to DONE.

## Structure
- Package ascii_disp_pkg holds:
  - state enum
  - ASCII_SPACE = 8'h20
  - BLANK_SEGS = 7'h7F
- Sub-module scroll_tick_gen: parameter TICK_DIV, inputs clk/reset/clr, output tick is a one-cycle pulse.
- Buffer is a register array so that all NUM_DIGITS read ports are available combinationally.

## Test plan
All scenarios use NUM_DIGITS=6, MSG_DEPTH=8, TICK_DIV=4 unless noted.
- Reset -> busy 0, wr_ready 1, msg_len 0, digit_blank 6'b111111, every digit_code 8'h20.
- Load 48 45 4C 4C 4F ("HELLO"), pulse start -> next cycle left-to-right H E L L O blank. Four cycles later E L L O blank blank. With loop off, done pulses 20 cycles after start, then busy 0.
- Write 8 chars -> wr_ready 0 after the 8th. A 9th wr_valid is held and not accepted, and msg_len stays 8.
- start with msg_len 0 -> busy stays 0 and display stays blank.
- Load "HELLO", start, stop after 2 ticks -> IDLE, display blank, msg_len 5. Start again -> H E L L O blank.
- SCROLL_LOOP_EN, message "AB" (P=8) -> after 8 ticks window is A B blank blank blank blank again, and done never pulses.
